// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared register offsets, bit indices and BCD digit limits.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TIME   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_RUNNING = 0;
    localparam int STAT_TICK    = 1;
    localparam int STAT_WRAP    = 2;

    localparam logic [3:0] SEC1_MAX = 4'd9;
    localparam logic [3:0] SEC2_MAX = 4'd5;
    localparam logic [3:0] MIN1_MAX = 4'd9;
    localparam logic [3:0] MIN2_MAX = 4'd5;

    function automatic logic [3:0] sat_digit(input logic [3:0] value, input logic [3:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mmss_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mmss_counter
// Description : Four-digit BCD mm:ss counter with clear, saturating load, inc.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mmss_counter
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  min1,
    output logic [3:0]  min2,
    output logic        wrap
);

    logic at_max;

    assign at_max = (sec1 == SEC1_MAX) && (sec2 == SEC2_MAX) &&
                    (min1 == MIN1_MAX) && (min2 == MIN2_MAX);
    assign wrap   = inc & ~clr & ~load & at_max;

    // Digits are always legal because loads saturate, so "== MAX" marks carry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec1 <= 4'd0;
            sec2 <= 4'd0;
            min1 <= 4'd0;
            min2 <= 4'd0;
        end else if (clr) begin
            sec1 <= 4'd0;
            sec2 <= 4'd0;
            min1 <= 4'd0;
            min2 <= 4'd0;
        end else if (load) begin
            sec1 <= sat_digit(load_val[3:0],   SEC1_MAX);
            sec2 <= sat_digit(load_val[7:4],   SEC2_MAX);
            min1 <= sat_digit(load_val[11:8],  MIN1_MAX);
            min2 <= sat_digit(load_val[15:12], MIN2_MAX);
        end else if (inc) begin
            if (sec1 != SEC1_MAX) begin
                sec1 <= sec1 + 4'd1;
            end else begin
                sec1 <= 4'd0;
                if (sec2 != SEC2_MAX) begin
                    sec2 <= sec2 + 4'd1;
                end else begin
                    sec2 <= 4'd0;
                    if (min1 != MIN1_MAX) begin
                        min1 <= min1 + 4'd1;
                    end else begin
                        min1 <= 4'd0;
                        min2 <= (min2 != MIN2_MAX) ? min2 + 4'd1 : 4'd0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_slave_stopwatch_regs.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_stopwatch_regs
// Description : Wishbone classic slave with stopwatch timebase and BCD time.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_stopwatch_regs
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int          DIV_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  min1,
    output logic [3:0]  min2,
    output logic        tick,
    output logic        irq
);

    logic             run, irq_en, tick_f, wrap_f;
    logic [DIV_W-1:0] div, presc, div_eff, div_wr;
    logic             req, wr;
    logic [1:0]       reg_sel;
    logic             wr_ctrl, wr_time, wr_status, wr_div, clear;
    logic [15:0]      time_now, time_wdata;
    logic             tick_now, wrap;
    logic [31:0]      rd_data;
    logic             unused_adr;

    assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    // A request is accepted only when ack is low, giving the every-other-cycle ack.
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_sel   = wb_adr_i[3:2];
    assign wr        = req & wb_we_i;
    assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
    assign wr_time   = wr && (reg_sel == REG_TIME);
    assign wr_status = wr && (reg_sel == REG_STATUS);
    assign wr_div    = wr && (reg_sel == REG_DIV);
    assign clear     = wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_CLEAR];

    assign time_now   = {min2, min1, sec2, sec1};
    assign time_wdata = {wb_sel_i[1] ? wb_dat_i[15:8] : time_now[15:8],
                         wb_sel_i[0] ? wb_dat_i[7:0]  : time_now[7:0]};

    assign div_eff  = (div == '0) ? DIV_W'(1) : div;
    assign tick_now = run && (presc == div_eff) && !clear;
    assign irq      = (tick_f | wrap_f) & irq_en;

    always_comb begin
        div_wr = div;
        for (int i = 0; i < DIV_W; i++) begin
            if (wb_sel_i[i/8]) div_wr[i] = wb_dat_i[i];
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_RUN]    = run;
                rd_data[CTRL_IRQ_EN] = irq_en;
            end
            REG_TIME:   rd_data[15:0] = time_now;
            REG_STATUS: begin
                rd_data[STAT_RUNNING] = run;
                rd_data[STAT_TICK]    = tick_f;
                rd_data[STAT_WRAP]    = wrap_f;
            end
            default:    rd_data[DIV_W-1:0] = div;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            run      <= 1'b0;
            irq_en   <= 1'b0;
            tick_f   <= 1'b0;
            wrap_f   <= 1'b0;
            div      <= DIV_W'(TICK_DIV - 1);
            presc    <= '0;
            tick     <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rd_data : '0;
            tick     <= tick_now;

            if (wr_ctrl && wb_sel_i[0]) begin
                run    <= wb_dat_i[CTRL_RUN];
                irq_en <= wb_dat_i[CTRL_IRQ_EN];
            end
            if (wr_div) div <= div_wr;

            // Overshoot after a smaller DIV write just wraps to 0 without a tick.
            if (clear) begin
                presc <= '0;
            end else if (run) begin
                presc <= (presc >= div_eff) ? '0 : presc + DIV_W'(1);
            end

            if (wr_status && wb_sel_i[0]) begin
                if (wb_dat_i[STAT_TICK]) tick_f <= 1'b0;
                if (wb_dat_i[STAT_WRAP]) wrap_f <= 1'b0;
            end
            if (tick_now) tick_f <= 1'b1;
            if (wrap)     wrap_f <= 1'b1;
        end
    end

    bcd_mmss_counter u_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (tick_now),
        .clr      (clear),
        .load     (wr_time),
        .load_val (time_wdata),
        .sec1     (sec1),
        .sec2     (sec2),
        .min1     (min1),
        .min2     (min2),
        .wrap     (wrap)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_stopwatch_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_slave_stopwatch_regs
// Description : Self-checking bench for the stopwatch Wishbone register slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slave_stopwatch_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
    logic [3:0]  sec1, sec2, min1, min2;
    logic        tick, irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pre;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [15:0] exp;
    } tvec_t;

    tvec_t vecs [7];

    wb_slave_stopwatch_regs dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .sec1     (sec1),
        .sec2     (sec2),
        .min1     (min1),
        .min2     (min2),
        .tick     (tick),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns two cycles later at a falling edge.
    task automatic bus(input logic we, input logic [1:0] r, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        wb_adr_i = {28'd0, r, 2'b00};
        wb_dat_i = d;
        wb_sel_i = s;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge clk);
        chk("bus_ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned t);
        int unsigned m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Byte-merged write with each digit clamped to its legal maximum.
    function automatic logic [15:0] time_model(input logic [15:0] pre, input logic [31:0] w,
                                               input logic [3:0] s);
        int lim [4];
        logic [15:0] r;
        int v;
        lim = '{9, 5, 9, 5};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = s[i/2] ? int'(w[4*i +: 4]) : int'(pre[4*i +: 4]);
            r[4*i +: 4] = 4'((v > lim[i]) ? lim[i] : v);
        end
        return r;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [15:0] pre, expt;
        logic [31:0] w;
        logic [3:0]  s;
        int unsigned d, p, t0, n, tk;

        rst = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dat", wb_dat_o, 32'd0);
        chk("reset_misc", {15'd0, wb_ack_o, min2, min1, sec2, sec1, tick, irq}, 32'd0);
        rst = 1'b1;
        bus(1'b0, 2'd3, 32'd0, 4'h0, rd); chk("reset_div", rd, 32'd49_999_999);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("reset_time", rd, 32'd0);
        bus(1'b0, 2'd0, 32'd0, 4'h0, rd); chk("reset_ctrl", rd, 32'd0);

        // Reset landing on a pending request drops the ack.
        wb_adr_i = 32'h8; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rst = 1'b0;
        @(negedge clk);
        chk("reset_midcycle_ack", {31'd0, wb_ack_o}, 32'd0);
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);

        bus(1'b1, 2'd3, 32'd3, 4'hF, rd);
        bus(1'b0, 2'd2, 32'd0, 4'h0, rd); chk("status_read", rd, 32'd0);

        // Held strobe on DIV: ack and data every other cycle.
        wb_adr_i = 32'hC; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("hold_ack", {31'd0, wb_ack_o}, 32'(i % 2));
            chk("hold_dat", wb_dat_o, (i % 2 == 1) ? 32'd3 : 32'd0);
            @(negedge clk);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);

        // Counting with DIV=3: one tick per four cycles.
        bus(1'b1, 2'd0, 32'h2, 4'h1, rd);
        bus(1'b1, 2'd0, 32'h1, 4'h1, rd);
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            chk("count_tick", {31'd0, tick}, 32'(((k + 1) % 4) == 0));
        end
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("count_time", rd, 32'h0010);
        bus(1'b1, 2'd0, 32'h0, 4'h1, rd);
        repeat (20) @(negedge clk);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("pause_time", rd, 32'h0010);
        bus(1'b1, 2'd0, 32'h1, 4'h1, rd);
        chk("resume_mid_second", {31'd0, tick}, 32'd1);

        // Wrap at 59:59 with irq enabled, then W1C.
        bus(1'b1, 2'd0, 32'h2, 4'h1, rd);
        bus(1'b1, 2'd2, 32'h6, 4'h1, rd);
        bus(1'b1, 2'd1, 32'h5959, 4'h3, rd);
        bus(1'b1, 2'd0, 32'h5, 4'h1, rd);
        repeat (3) @(negedge clk);
        chk("wrap_tick", {31'd0, tick}, 32'd1);
        chk("wrap_irq", {31'd0, irq}, 32'd1);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("wrap_time", rd, 32'h0000);
        bus(1'b0, 2'd2, 32'd0, 4'h0, rd); chk("wrap_status", rd, 32'h7);
        bus(1'b1, 2'd2, 32'h6, 4'h1, rd);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        bus(1'b1, 2'd0, 32'h0, 4'h1, rd);

        // TIME byte enables and saturation.
        vecs[0] = '{16'h0000, 32'h0000FFFF, 4'b0001, 16'h0059};
        vecs[1] = '{16'h0059, 32'h0000AB7C, 4'b0011, 16'h5959};
        vecs[2] = '{16'h1234, 32'h00009999, 4'b0010, 16'h5934};
        vecs[3] = '{16'h1234, 32'h00000000, 4'b0000, 16'h1234};
        vecs[4] = '{16'h0000, 32'h00004321, 4'b1100, 16'h0000};
        vecs[5] = '{16'h0000, 32'h00005A3B, 4'b0011, 16'h5939};
        vecs[6] = '{16'h0000, 32'h00006070, 4'b0011, 16'h5050};
        for (int i = 0; i < 7; i++) begin
            bus(1'b1, 2'd1, {16'd0, vecs[i].pre}, 4'h3, rd);
            bus(1'b1, 2'd1, vecs[i].wdata, vecs[i].sel, rd);
            bus(1'b0, 2'd1, 32'd0, 4'h0, rd);
            chk("time_vec", rd, {16'd0, vecs[i].exp});
        end
        for (int i = 0; i < 10; i++) begin
            pre = to_bcd($urandom_range(0, 3599));
            w   = $urandom;
            s   = 4'($urandom_range(0, 15));
            expt = time_model(pre, w, s);
            bus(1'b1, 2'd1, {16'd0, pre}, 4'h3, rd);
            bus(1'b1, 2'd1, w, s, rd);
            bus(1'b0, 2'd1, 32'd0, 4'h0, rd);
            chk("time_rand", rd, {16'd0, expt});
        end

        // Clear coincident with a tick, then a TIME write coincident with a tick.
        bus(1'b1, 2'd0, 32'h2, 4'h1, rd);
        bus(1'b1, 2'd1, 32'h0321, 4'h3, rd);
        bus(1'b1, 2'd2, 32'h6, 4'h1, rd);
        bus(1'b1, 2'd0, 32'h1, 4'h1, rd);
        repeat (2) @(negedge clk);
        bus(1'b1, 2'd0, 32'h3, 4'h1, rd);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("clear_time", rd, 32'h0000);
        bus(1'b0, 2'd2, 32'd0, 4'h0, rd); chk("clear_run_kept", rd & 32'h1, 32'h1);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("clear_presc_restart", rd, 32'h0001);
        bus(1'b1, 2'd1, 32'h1234, 4'h3, rd);
        bus(1'b0, 2'd1, 32'd0, 4'h0, rd); chk("load_beats_tick", rd, 32'h1234);

        // Randomised run periods against an arithmetic seconds model.
        for (int it = 0; it < 8; it++) begin
            d  = $urandom_range(0, 5);
            p  = (d == 0) ? 2 : d + 1;
            t0 = ($urandom_range(0, 1) == 1) ? 3600 - $urandom_range(1, 6) : $urandom_range(0, 3599);
            n  = $urandom_range(8, 40);
            bus(1'b1, 2'd0, 32'h2, 4'h1, rd);
            bus(1'b1, 2'd2, 32'h6, 4'h1, rd);
            bus(1'b1, 2'd3, d, 4'hF, rd);
            bus(1'b1, 2'd1, {16'd0, to_bcd(t0)}, 4'h3, rd);
            bus(1'b1, 2'd0, 32'h1, 4'h1, rd);
            for (int k = 1; k <= int'(n); k++) begin
                @(negedge clk);
                chk("rand_tick", {31'd0, tick}, 32'(((k + 1) % int'(p)) == 0));
            end
            bus(1'b0, 2'd1, 32'd0, 4'h0, rd);
            chk("rand_time", rd, {16'd0, to_bcd((t0 + (n + 1) / p) % 3600)});
            tk = (n + 3) / p;
            bus(1'b0, 2'd2, 32'd0, 4'h0, rd);
            chk("rand_status", rd, {29'd0, (t0 + tk) >= 3600, tk > 0, 1'b1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
